// File: rtl/prf_freelist.sv
// Free-list manager for the split ALU/MEM physical register file.
// Each bank holds a circular FIFO of free indices and a busy vector that flags double or bogus frees.
module prf_freelist #(
    parameter int LG_DEPTH   = 7,
    parameter int N_RESERVED = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alloc_alu_req,
    output logic                alloc_alu_avail,
    output logic [LG_DEPTH-1:0] alloc_alu_ptr,
    input  logic                alloc_mem_req,
    output logic                alloc_mem_avail,
    output logic [LG_DEPTH-1:0] alloc_mem_ptr,
    input  logic                free0_valid,
    input  logic [LG_DEPTH-1:0] free0_ptr,
    input  logic                free1_valid,
    input  logic [LG_DEPTH-1:0] free1_ptr,
    output logic [LG_DEPTH-1:0] alu_free_cnt,
    output logic [LG_DEPTH-1:0] mem_free_cnt,
    output logic                err
);

    localparam int IW      = LG_DEPTH - 1;
    localparam int H_DEPTH = 1 << IW;

    typedef logic [IW-1:0]       idx_t;
    typedef logic [LG_DEPTH-1:0] cnt_t;

    // Index 0 is the ALU bank (pointer MSB 0), index 1 the MEM bank (pointer MSB 1).
    idx_t               r_fifo [2][H_DEPTH];
    idx_t               r_head [2];
    idx_t               r_tail [2];
    cnt_t               r_cnt  [2];
    logic [H_DEPTH-1:0] r_busy [2];
    logic               r_err;

    logic [1:0] w_req;
    logic [1:0] w_pop;
    logic [1:0] w_push0;
    logic [1:0] w_push1;
    logic [1:0] w_bank_err;
    idx_t       w_lo0;
    idx_t       w_lo1;

    assign w_req = {alloc_mem_req, alloc_alu_req};
    assign w_lo0 = free0_ptr[IW-1:0];
    assign w_lo1 = free1_ptr[IW-1:0];

    always_comb begin
        logic f0_hit;
        logic f1_hit;
        logic dup;
        cnt_t room;
        // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
        w_pop      = '0;
        w_push0    = '0;
        w_push1    = '0;
        w_bank_err = '0;
        f0_hit     = 1'b0;
        f1_hit     = 1'b0;
        dup        = 1'b0;
        room       = '0;
        for (int b = 0; b < 2; b++) begin
            f0_hit = free0_valid && (free0_ptr != '0) && (free0_ptr[LG_DEPTH-1] == b[0]);
            f1_hit = free1_valid && (free1_ptr != '0) && (free1_ptr[LG_DEPTH-1] == b[0]);
            dup    = f0_hit && f1_hit && (free0_ptr == free1_ptr);
            // Pop is judged on the count at cycle start; a same-cycle push never enables it.
            w_pop[b] = w_req[b] && (r_cnt[b] != '0);
            room     = cnt_t'(H_DEPTH) - r_cnt[b] + cnt_t'(w_pop[b]);
            w_push0[b] = f0_hit && r_busy[b][w_lo0] && (room != '0);
            w_push1[b] = f1_hit && !dup && r_busy[b][w_lo1] && (room > cnt_t'(w_push0[b]));
            w_bank_err[b] = (w_req[b] && !w_pop[b])
                          || (f0_hit && !w_push0[b])
                          || (f1_hit && !w_push1[b]);
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every read sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                r_head[b] <= '0;
                r_tail[b] <= idx_t'(H_DEPTH - N_RESERVED);
                r_cnt[b]  <= cnt_t'(H_DEPTH - N_RESERVED);
                // NOTE: the FIFO storage is reset on purpose; it must come up holding the initial free list.
                for (int i = 0; i < H_DEPTH; i++) begin
                    r_fifo[b][i] <= idx_t'(N_RESERVED + i);
                    r_busy[b][i] <= (i < N_RESERVED);
                end
            end
            r_err <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_pop[b]) begin
                    r_head[b] <= r_head[b] + idx_t'(1);
                    r_busy[b][r_fifo[b][r_head[b]]] <= 1'b1;
                end
                if (w_push0[b]) begin
                    r_fifo[b][r_tail[b]] <= w_lo0;
                    r_busy[b][w_lo0]     <= 1'b0;
                end
                if (w_push1[b]) begin
                    r_fifo[b][r_tail[b] + idx_t'(w_push0[b])] <= w_lo1;
                    r_busy[b][w_lo1]                          <= 1'b0;
                end
                r_tail[b] <= r_tail[b] + idx_t'(w_push0[b]) + idx_t'(w_push1[b]);
                r_cnt[b]  <= r_cnt[b] - cnt_t'(w_pop[b]) + cnt_t'(w_push0[b]) + cnt_t'(w_push1[b]);
            end
            r_err <= r_err || (|w_bank_err);
        end
    end

    assign alloc_alu_avail = (r_cnt[0] != '0);
    assign alloc_alu_ptr   = {1'b0, r_fifo[0][r_head[0]]};
    assign alloc_mem_avail = (r_cnt[1] != '0);
    assign alloc_mem_ptr   = {1'b1, r_fifo[1][r_head[1]]};
    assign alu_free_cnt    = r_cnt[0];
    assign mem_free_cnt    = r_cnt[1];
    assign err             = r_err;

`ifdef PRF_FREELIST_STOP_ON_ERR
    // Halts simulation on the first protocol error when this macro is defined.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (r_err || !(|w_bank_err)) else $stop;
        end
    end
`endif

endmodule
